// File: rtl/dac_spi_tx.sv
// dac_spi_tx: samples a 12-bit audio bus at a fixed rate and ships each sample to an MCP4921-style SPI DAC
module dac_spi_tx #(
    parameter int          CLK_DIV    = 4,
    parameter int          SAMPLE_DIV = 2268,
    parameter logic [3:0]  CONFIG     = 4'b0011
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [11:0] audio_i,
    input  logic        ena_i,
    output logic        sck_o,
    output logic        mosi_o,
    output logic        cs_n_o,
    output logic        ldac_n_o,
    output logic        busy_o,
    output logic        sample_strobe_o,
    output logic        overrun_o
);
    localparam int TW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
    localparam int HW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LDAC} state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [15:0]   shreg_q;
    logic [3:0]    bitcnt_q;
    logic          sck_q, mosi_q, cs_n_q, ldac_n_q, busy_q, strobe_q, ovr_q;
    logic          tick, step;

    // sample tick and SCK half-period step, plus their wrapping next values
    always_comb begin
        tick    = timer_q == TW'(SAMPLE_DIV - 1);
        step    = hcnt_q == HW'(CLK_DIV - 1);
        timer_d = tick ? '0 : timer_q + 1'b1;
        hcnt_d  = step ? '0 : hcnt_q + 1'b1;
    end

    // free-running sample timer, independent of ena and FSM state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) timer_q <= '0;
        else         timer_q <= timer_d;
    end

    // frame sequencer: every non-IDLE state advances once per SCK half-period
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (tick && state_q != IDLE) ovr_q <= 1'b1;
            if (state_q == IDLE) begin
                if (tick && ena_i) begin
                    shreg_q  <= {CONFIG, audio_i};
                    mosi_q   <= CONFIG[3];
                    cs_n_q   <= 1'b0;
                    strobe_q <= 1'b1;
                    busy_q   <= 1'b1;
                    hcnt_q   <= '0;
                    state_q  <= SETUP;
                end
            end else begin
                hcnt_q <= hcnt_d;
                if (step) begin
                    case (state_q)
                        SETUP: begin
                            sck_q    <= 1'b1;
                            bitcnt_q <= '0;
                            state_q  <= SHIFT;
                        end
                        SHIFT: begin
                            if (sck_q) begin
                                sck_q   <= 1'b0;
                                shreg_q <= shreg_q << 1;
                                mosi_q  <= shreg_q[14];
                            end else if (bitcnt_q == 4'd15) begin
                                state_q <= HOLD;
                            end else begin
                                sck_q    <= 1'b1;
                                bitcnt_q <= bitcnt_q + 4'd1;
                            end
                        end
                        HOLD: begin
                            cs_n_q   <= 1'b1;
                            ldac_n_q <= 1'b0;
                            state_q  <= LDAC;
                        end
                        default: begin
                            ldac_n_q <= 1'b1;
                            mosi_q   <= 1'b0;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign sck_o           = sck_q;
    assign mosi_o          = mosi_q;
    assign cs_n_o          = cs_n_q;
    assign ldac_n_o        = ldac_n_q;
    assign busy_o          = busy_q;
    assign sample_strobe_o = strobe_q;
    assign overrun_o       = ovr_q;
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: scoreboard bench for dac_spi_tx, a legal-rate instance and an overrunning one side by side
module tb_dac_spi_tx;
    localparam int CD  = 2;
    localparam int FL  = 35 * CD;
    localparam int CSL = 34 * CD;
    localparam int LDL = CD;

    logic clk = 0, rst_n = 0, ena = 0;
    logic [11:0] audio = 0;
    logic [1:0] sck, mosi, cs_n, ldac_n, busy, strb, ovr;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    dac_spi_tx #(.CLK_DIV(CD), .SAMPLE_DIV(80)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .audio_i(audio), .ena_i(ena),
        .sck_o(sck[0]), .mosi_o(mosi[0]), .cs_n_o(cs_n[0]), .ldac_n_o(ldac_n[0]),
        .busy_o(busy[0]), .sample_strobe_o(strb[0]), .overrun_o(ovr[0]));

    dac_spi_tx #(.CLK_DIV(CD), .SAMPLE_DIV(40)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .audio_i(audio), .ena_i(ena),
        .sck_o(sck[1]), .mosi_o(mosi[1]), .cs_n_o(cs_n[1]), .ldac_n_o(ldac_n[1]),
        .busy_o(busy[1]), .sample_strobe_o(strb[1]), .overrun_o(ovr[1]));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference model: timer, frame occupancy, expected strobe/overrun; pushes expected frames
    int mt[2], mb[2], wp[2], rp[2];
    bit movr[2], estrb[2];
    logic [15:0] fifo[2][8];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                mt[d] = 0; mb[d] = 0; movr[d] = 0; estrb[d] = 0;
            end else begin
                int sd;
                bit tk, idle;
                sd = (d == 0) ? 80 : 40;
                tk = mt[d] == sd - 1;
                idle = mb[d] == 0;
                estrb[d] = 0;
                if (tk && !idle) movr[d] = 1;
                if (tk && idle && ena) begin
                    fifo[d][wp[d] % 8] = {4'h3, audio};
                    wp[d]++;
                    mb[d] = FL;
                    estrb[d] = 1;
                end else if (!idle) mb[d]--;
                mt[d] = tk ? 0 : mt[d] + 1;
            end
        end
    end

    // monitor: captures SPI frames from the pins and compares against the scoreboard
    logic [15:0] sr[2], lastf[2];
    int nb[2], lowc[2], ldc[2], tog[2];
    bit psck[2], pcs[2] = '{1'b1, 1'b1}, pld[2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                pcs[d] = 1; psck[d] = 0; pld[d] = 1;
                ldc[d] = 0; tog[d] = 0; nb[d] = 0; lowc[d] = 0;
                rp[d] = wp[d];
            end else begin
                if (strb[d] || estrb[d]) chk($sformatf("strobe%0d", d), strb[d], estrb[d]);
                if (busy[d] || mb[d] != 0) chk($sformatf("busy%0d", d), busy[d], mb[d] != 0);
                if (ovr[d] || movr[d]) chk($sformatf("overrun%0d", d), ovr[d], movr[d]);
                if (pcs[d] && !cs_n[d]) begin
                    nb[d] = 0; sr[d] = 0; lowc[d] = 0;
                end
                if (!cs_n[d]) lowc[d]++;
                if (!cs_n[d] && !psck[d] && sck[d]) begin
                    sr[d] = {sr[d][14:0], mosi[d]};
                    nb[d]++;
                end
                if (cs_n[d] && pcs[d] && sck[d] != psck[d]) tog[d]++;
                if (!pcs[d] && cs_n[d]) begin
                    chk($sformatf("frame_queued%0d", d), rp[d] != wp[d], 1);
                    if (rp[d] != wp[d]) begin
                        chk($sformatf("frame_data%0d", d), sr[d], fifo[d][rp[d] % 8]);
                        rp[d]++;
                    end
                    chk($sformatf("frame_bits%0d", d), nb[d], 16);
                    chk($sformatf("cs_low_len%0d", d), lowc[d], CSL);
                    chk($sformatf("ldac_at_cs_rise%0d", d), ldac_n[d], 0);
                    chk($sformatf("sck_idle_toggles%0d", d), tog[d], 0);
                    tog[d] = 0;
                    lastf[d] = sr[d];
                end
                if (!ldac_n[d]) ldc[d]++;
                if (!pld[d] && ldac_n[d]) begin
                    chk($sformatf("ldac_len%0d", d), ldc[d], LDL);
                    ldc[d] = 0;
                end
                pcs[d] = cs_n[d]; psck[d] = sck[d]; pld[d] = ldac_n[d];
            end
        end
    end

    task automatic cyc(input int n, input bit vary);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (vary && i % 7 == 0) audio = audio * 12'd5 + 12'h3B1;
        end
    endtask

    task automatic first_strobe(input string nm);
        int k;
        k = 0;
        for (int i = 1; i <= 200 && k == 0; i++) begin
            @(negedge clk);
            if (strb[0]) k = i;
        end
        chk(nm, k, 80);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n;
        bit ps;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ena = i[0];
            audio = 12'(i * 12'h29B);
            #1;
            chk("reset_outputs", {sck, mosi, cs_n, ldac_n, busy, strb, ovr},
                {2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00});
        end
        audio = 12'hA5C;
        ena = 1;
        @(negedge clk); #1 rst_n = 1;
        first_strobe("first_strobe_delay");
        cyc(100, 0);
        chk("frame_A5C_dut0", lastf[0], 16'h3A5C);
        chk("frame_A5C_dut1", lastf[1], 16'h3A5C);
        chk("overrun_dut1_set", ovr[1], 1);
        chk("overrun_dut0_clear", ovr[0], 0);
        cyc(420, 1);
        ena = 0;
        cyc(240, 0);
        cyc(37, 0);
        ena = 1;
        cyc(200, 1);
        audio = 12'h7E1;
        k = 0;
        while (!busy[0] && k < 200) begin @(negedge clk); k++; end
        chk("busy_wait", busy[0], 1);
        ps = sck[0]; n = 0; k = 0;
        while (n < 10 && k < 500) begin
            @(posedge clk); #1;
            if (sck[0] && !ps) n++;
            ps = sck[0]; k++;
        end
        chk("sck_rise_wait", n, 10);
        rst_n = 0;
        #1;
        chk("midframe_reset_cs_n", cs_n[0], 1);
        chk("midframe_reset_sck", sck[0], 0);
        chk("midframe_reset_busy", busy[0], 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1;
        first_strobe("strobe_after_reset");
        cyc(100, 0);
        chk("frame_after_reset", lastf[0], 16'h37E1);
        ena = 0;
        cyc(200, 0);
        chk("queue_drained0", wp[0] - rp[0], 0);
        chk("queue_drained1", wp[1] - rp[1], 0);
        chk("overrun_dut1_sticky", ovr[1], 1);
        chk("overrun_dut0_final", ovr[0], 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
